display_scan_control: RTL and testbench

Time-multiplexing controller for the 4-digit seven-segment display. Generates the 2-bit digit select that steers the downstream hex digit mux, drives the active-low anode lines with an inter-digit blanking gap to suppress ghosting, and holds the displayed 16-bit value in double-buffered registers. A valid/ready handshake loads new values, and the swap happens only at a frame boundary so a frame never shows a mix of old and new digits.

---
 rtl/display_scan_control.sv | 123 ++++++++++++
 tb/tb_display_scan_control.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_control.sv
// Four-digit seven-segment scan controller: prescaled digit select, blanked anode drive,
// and a double-buffered display value. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scan_control #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        enable,
  output logic [3:0]  digit_1,
  output logic [3:0]  digit_2,
  output logic [3:0]  digit_3,
  output logic [3:0]  digit_4,
  output logic [1:0]  refresh_count,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t      state_reg, state_next;
  logic [PW-1:0] pcnt_reg, pcnt_next;
  logic [1:0]  rc_reg, rc_next;
  logic [3:0]  an_reg, an_next;
  logic        frame_done_reg, frame_done_next;
  logic [15:0] disp_reg, disp_next;
  logic [15:0] shadow_reg;
  logic        pending_reg, pending_next;
  logic        slot_end, frame_end, transfer;
  logic [3:0]  sel_mask, lz_mask;

  assign slot_end  = (pcnt_reg == PCNT_LAST);
  assign frame_end = slot_end && (rc_reg == 2'd3);
  assign transfer  = value_valid && !pending_reg;

  assign pcnt_next    = slot_end ? '0 : pcnt_reg + 1'b1;
  assign rc_next      = slot_end ? rc_reg + 2'd1 : rc_reg;
  assign pending_next = transfer | (pending_reg & ~frame_end);
  assign disp_next    = (frame_end && pending_reg) ? shadow_reg : disp_reg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (BLANK_CYCLES == 0) begin
      state_next = S_DRIVE;
    end else if (slot_end) begin
      state_next = S_BLANK;
    end else if (state_reg == S_BLANK && pcnt_reg == BLANK_LAST) begin
      state_next = S_DRIVE;
    end
  end

  // Outputs are computed from next-cycle values so anodes and select change on the same edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sel
    assign sel_mask[gi] = (rc_next == 2'(gi));
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed only if it and every digit to its left are zero; digit_1 never is.
  assign lz_mask[3] = (disp_next[15:12] == 4'h0);
  assign lz_mask[2] = lz_mask[3] && (disp_next[11:8] == 4'h0);
  assign lz_mask[1] = lz_mask[2] && (disp_next[7:4] == 4'h0);
  assign lz_mask[0] = 1'b0;
`else
  assign lz_mask = 4'b0000;
`endif

  always_comb begin
    an_next = 4'b1111;
    if (enable && state_next == S_DRIVE) begin
      an_next = ~(sel_mask & ~lz_mask);
    end
    frame_done_next = (pcnt_next == PCNT_LAST) && (rc_next == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_reg       <= '0;
      rc_reg         <= 2'd0;
      an_reg         <= 4'b1111;
      frame_done_reg <= 1'b0;
      disp_reg       <= 16'h0000;
      shadow_reg     <= 16'h0000;
      pending_reg    <= 1'b0;
    end else begin
      pcnt_reg       <= pcnt_next;
      rc_reg         <= rc_next;
      an_reg         <= an_next;
      frame_done_reg <= frame_done_next;
      disp_reg       <= disp_next;
      pending_reg    <= pending_next;
      if (transfer) begin
        shadow_reg <= value;
      end
    end
  end

  assign value_ready   = !pending_reg;
  assign refresh_count = rc_reg;
  assign an            = an_reg;
  assign frame_done    = frame_done_reg;
  assign digit_1       = disp_reg[3:0];
  assign digit_2       = disp_reg[7:4];
  assign digit_3       = disp_reg[11:8];
  assign digit_4       = disp_reg[15:12];

endmodule

// File: tb/tb_display_scan_control.sv
// Randomized bench for display_scan_control; the reference model derives every expected
// output from a cycle count since reset and the time each accepted value is due on screen.
module tb_display_scan_control;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        enable;
  logic [3:0]  digit_1, digit_2, digit_3, digit_4;
  logic [1:0]  refresh_count;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Model: n = cycles since reset, m_pend/m_shadow/m_until = value waiting for frame end m_until.
  int          n;
  bit          m_pend;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;
  int          m_until;
  bit          m_en;
  bit          accepted;

  always #5 clk = ~clk;

  display_scan_control #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .enable(enable),
    .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3), .digit_4(digit_4),
    .refresh_count(refresh_count), .an(an), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d since reset)", tag, got, exp, n);
    end
  endtask

  function automatic logic [3:0] exp_an();
    int p, k;
    logic [3:0] one;
    one = 4'b0001;
    p = n % DIV;
    k = (n / DIV) % 4;
    if (!m_en || p < BLANK) return 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
    if (k >= 1 && (m_disp >> (4 * k)) == 16'h0000) return 4'b1111;
`endif
    return ~(one << k);
  endfunction

  task automatic step();
    int c;
    bit ready_before;
    @(posedge clk);
    accepted = 0;
    if (reset) begin
      n = 0; m_pend = 0; m_shadow = '0; m_disp = '0; m_en = enable;
    end else begin
      c = n;
      ready_before = !m_pend;
      if (m_pend && c == m_until) begin
        m_disp = m_shadow;
        m_pend = 0;
      end
      if (value_valid && ready_before) begin
        m_shadow = value;
        m_pend   = 1;
        m_until  = c - (c % FRAME) + FRAME - 1 + (((c % FRAME) == FRAME - 1) ? FRAME : 0);
        accepted = 1;
        $display("load %h at cycle %0d, due on display after cycle %0d", value, c, m_until);
      end
      m_en = enable;
      n = n + 1;
    end
    @(negedge clk);
    check("refresh_count", 32'(refresh_count), 32'((n / DIV) % 4));
    check("an", 32'(an), 32'(exp_an()));
    check("frame_done", 32'(frame_done), 32'((n % FRAME) == FRAME - 1));
    check("value_ready", 32'(value_ready), 32'(!m_pend));
    check("digits", 32'({digit_4, digit_3, digit_2, digit_1}), 32'(m_disp));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_phase(input int mod, input int p);
    for (int i = 0; i < FRAME && (n % mod) != p; i++) step();
  endtask

  task automatic load(input logic [15:0] v);
    bit done;
    done = 0;
    value = v;
    value_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME && !done; i++) begin
      step();
      done = accepted;
    end
    value_valid = 1'b0;
    check("load_accepted", 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; value = '0; value_valid = 1'b0; enable = 1'b1;
    n = 0; m_pend = 0; m_shadow = '0; m_disp = '0; m_until = 0; m_en = 1;
    run(2);
    reset = 1'b0;
    run(70);

    wait_phase(FRAME, 10);
    load(16'hA5C3);
    run(40);

    load(16'h1234);
    load(16'h5678);
    run(70);

    run(FRAME);
    wait_phase(FRAME, FRAME - 1);
    value = 16'hBEEF; value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    check("frame_end_accept", 32'(accepted), 32'd1);
    run(70);

    enable = 1'b0;
    run(40);
    enable = 1'b1;
    run(40);

    load(16'h0070);
    run(80);

    load(16'h9ABC);
    wait_phase(DIV, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(20);

    load(16'h0070);
    run(80);
    load(16'h0000);
    run(80);

    for (int i = 0; i < 800; i++) begin
      value       = 16'($urandom);
      value_valid = ($urandom_range(0, 3) == 0);
      enable      = ($urandom_range(0, 15) != 0);
      reset       = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; value_valid = 1'b0; enable = 1'b1;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
